// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer types and HTRANS encodings.
package ahb_pkg;
  typedef logic [1:0] htrans_t;
  typedef logic mst_idx_t;
  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_BUSY   = 2'b01;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;
  localparam htrans_t HTRANS_SEQ    = 2'b11;
endpackage

// File: rtl/ahb_arb_pick.sv
// ahb_arb_pick: next-grant selection; AHB_ARB_RR_EN selects round-robin ties, else master 0 wins.
module ahb_arb_pick
  import ahb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       hold,
  input  logic [1:0] grant_q,
`ifdef AHB_ARB_RR_EN
  input  mst_idx_t   last_owner,
`endif
  output logic [1:0] grant_d
);
  logic [1:0] win;
  always_comb begin
`ifdef AHB_ARB_RR_EN
    win = (&req) ? (last_owner ? 2'b01 : 2'b10) : (req[1] & ~req[0]) ? 2'b10 : 2'b01;
`else
    win = (req[1] & ~req[0]) ? 2'b10 : 2'b01;
`endif
    grant_d = hold ? grant_q : win;
  end
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master AHB-Lite arbiter with grant, address/data owner tracking and bus muxes (AHB_ARB_RR_EN enables round-robin).
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [1:0]        HBUSREQ,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  htrans_t           M0_HTRANS,
  input  htrans_t           M1_HTRANS,
  input  logic              M0_HWRITE,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  input  logic [DATA_W-1:0] M1_HWDATA,
  input  logic              HREADY,
  output logic [1:0]        HGRANT,
  output logic              HMASTER,
  output logic              HMASTER_D,
  output logic [ADDR_W-1:0] HADDR,
  output htrans_t           HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA
);
  logic [1:0] grant_q, grant_d, pick_grant;
  mst_idx_t   addr_own_q, addr_own_d, data_own_q, data_own_d;
  logic       hold;
`ifdef AHB_ARB_RR_EN
  mst_idx_t   last_owner_q, last_owner_d;
`endif

  always_comb begin
    HADDR      = addr_own_q ? M1_HADDR : M0_HADDR;
    HTRANS     = addr_own_q ? M1_HTRANS : M0_HTRANS;
    HWRITE     = addr_own_q ? M1_HWRITE : M0_HWRITE;
    HSIZE      = addr_own_q ? M1_HSIZE : M0_HSIZE;
    HWDATA     = data_own_q ? M1_HWDATA : M0_HWDATA;
    hold       = (HTRANS == HTRANS_SEQ) || (HTRANS == HTRANS_BUSY) ||
                 (HBUSREQ[addr_own_q] && HTRANS == HTRANS_NONSEQ);
    grant_d    = HREADY ? pick_grant : grant_q;
    addr_own_d = HREADY ? grant_q[1] : addr_own_q;
    data_own_d = HREADY ? addr_own_q : data_own_q;
`ifdef AHB_ARB_RR_EN
    last_owner_d = HREADY ? grant_q[1] : last_owner_q;
`endif
    HGRANT     = grant_q;
    HMASTER    = addr_own_q;
    HMASTER_D  = data_own_q;
  end

  ahb_arb_pick u_pick (
    .req        (HBUSREQ),
    .hold       (hold),
    .grant_q    (grant_q),
`ifdef AHB_ARB_RR_EN
    .last_owner (last_owner_q),
`endif
    .grant_d    (pick_grant)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q    <= 2'b01;
      addr_own_q <= 1'b0;
      data_own_q <= 1'b0;
`ifdef AHB_ARB_RR_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      grant_q    <= grant_d;
      addr_own_q <= addr_own_d;
      data_own_q <= data_own_d;
`ifdef AHB_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed and randomized checks of ahb_arbiter against an index-based reference model.
module tb_ahb_arbiter;
  logic        HCLK, HRESET, HREADY;
  logic [1:0]  HBUSREQ, M0_HTRANS, M1_HTRANS, HGRANT, HTRANS;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, HADDR, HWDATA;
  logic        M0_HWRITE, M1_HWRITE, HMASTER, HMASTER_D, HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE, HSIZE;
  int vectors = 0, errors = 0;
  int mg = 0, mm = 0, md = 0, ml = 0;

  ahb_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ),
    .M0_HADDR(M0_HADDR), .M1_HADDR(M1_HADDR), .M0_HTRANS(M0_HTRANS), .M1_HTRANS(M1_HTRANS),
    .M0_HWRITE(M0_HWRITE), .M1_HWRITE(M1_HWRITE), .M0_HSIZE(M0_HSIZE), .M1_HSIZE(M1_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M1_HWDATA(M1_HWDATA), .HREADY(HREADY),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTER_D(HMASTER_D),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA)
  );

  always #5 HCLK = ~HCLK;

  // Reference: the master whose transfer is in its address phase keeps the bus through bursts.
  function automatic int model_pick();
    int tr;
    bit busy;
    tr = (mm == 1) ? int'(M1_HTRANS) : int'(M0_HTRANS);
    busy = (tr == 3) || (tr == 1) || (HBUSREQ[mm] && tr == 2);
    if (busy) return mg;
    if (HBUSREQ == 2'b10) return 1;
`ifdef AHB_ARB_RR_EN
    if (HBUSREQ == 2'b11) return (ml == 0) ? 1 : 0;
`endif
    return 0;
  endfunction

  always @(posedge HCLK) begin
    if (HRESET) begin
      mg <= 0; mm <= 0; md <= 0; ml <= 0;
    end else if (HREADY) begin
      mg <= model_pick(); mm <= mg; md <= mm; ml <= mg;
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic rand_inputs();
    HBUSREQ = 2'($urandom); M0_HTRANS = 2'($urandom); M1_HTRANS = 2'($urandom);
    M0_HADDR = $urandom; M1_HADDR = $urandom; M0_HWDATA = $urandom; M1_HWDATA = $urandom;
    M0_HWRITE = 1'($urandom); M1_HWRITE = 1'($urandom);
    M0_HSIZE = 3'($urandom); M1_HSIZE = 3'($urandom);
  endtask

  task automatic do_reset();
    HRESET = 1; HREADY = 1; HBUSREQ = 2'b00; M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
    tick();
    HRESET = 0;
  endtask

  task automatic test_reset();
    rand_inputs();
    HREADY = 1'($urandom);
    HRESET = 1;
    tick(); tick();
    vectors++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL reset_grant got %b want 01", HGRANT); end
    vectors++; if (HMASTER !== 1'b0 || HMASTER_D !== 1'b0) begin errors++; $display("FAIL reset_owner got %b/%b want 0/0", HMASTER, HMASTER_D); end
    vectors++; if (HADDR !== M0_HADDR) begin errors++; $display("FAIL reset_haddr got %h want %h", HADDR, M0_HADDR); end
    HRESET = 0;
  endtask

  task automatic test_single();
    do_reset();
    HBUSREQ = 2'b10; M1_HADDR = 32'h2000_0010; M1_HWDATA = $urandom;
    tick();
    vectors++; if (HGRANT !== 2'b10 || HMASTER !== 1'b0) begin errors++; $display("FAIL single_grant got %b/%b want 10/0", HGRANT, HMASTER); end
    tick();
    vectors++; if (HMASTER !== 1'b1 || HMASTER_D !== 1'b0) begin errors++; $display("FAIL single_owner got %b/%b want 1/0", HMASTER, HMASTER_D); end
    vectors++; if (HADDR !== 32'h2000_0010) begin errors++; $display("FAIL single_haddr got %h want 20000010", HADDR); end
    tick();
    vectors++; if (HMASTER_D !== 1'b1 || HWDATA !== M1_HWDATA) begin errors++; $display("FAIL single_data got %b/%h want 1/%h", HMASTER_D, HWDATA, M1_HWDATA); end
  endtask

  task automatic test_wait_states();
    do_reset();
    HBUSREQ = 2'b10;
    tick();
    HREADY = 0;
    for (int i = 0; i < 3; i++) begin
      M0_HWDATA = $urandom; M1_HWDATA = $urandom;
      tick();
      vectors++; if (HGRANT !== 2'b10 || HMASTER !== 1'b0 || HMASTER_D !== 1'b0) begin errors++; $display("FAIL wait_frozen%0d got %b/%b/%b want 10/0/0", i, HGRANT, HMASTER, HMASTER_D); end
      vectors++; if (HWDATA !== M0_HWDATA) begin errors++; $display("FAIL wait_hwdata%0d got %h want %h", i, HWDATA, M0_HWDATA); end
    end
    HREADY = 1;
    tick();
    vectors++; if (HMASTER !== 1'b1 || HMASTER_D !== 1'b0 || HWDATA !== M0_HWDATA) begin errors++; $display("FAIL wait_resume got %b/%b/%h want 1/0/%h", HMASTER, HMASTER_D, HWDATA, M0_HWDATA); end
    tick();
    vectors++; if (HMASTER_D !== 1'b1 || HWDATA !== M1_HWDATA) begin errors++; $display("FAIL wait_dataflip got %b/%h want 1/%h", HMASTER_D, HWDATA, M1_HWDATA); end
  endtask

  task automatic test_burst_hold();
    do_reset();
    HBUSREQ = 2'b11; M0_HTRANS = 2'b10;
    tick();
    vectors++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL burst_nonseq got %b want 01", HGRANT); end
    M0_HTRANS = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL burst_seq%0d got %b want 01", i, HGRANT); end
    end
    M0_HTRANS = 2'b00; HBUSREQ = 2'b10;
    tick();
    vectors++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL burst_release got %b want 10", HGRANT); end
  endtask

  task automatic test_tie();
    do_reset();
    HBUSREQ = 2'b11; M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++; if (HMASTER !== 1'(mm) || HGRANT !== (mg == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie%0d got %b/%b want %0d/%0d", i, HMASTER, HGRANT, mm, mg); end
`ifndef AHB_ARB_RR_EN
      vectors++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL tie_fixed%0d got %b want 0", i, HMASTER); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    HBUSREQ = 2'b10;
    tick(); tick();
    vectors++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL mid_setup got %b want 1", HMASTER); end
    HREADY = 0; HRESET = 1;
    tick();
    vectors++; if (HGRANT !== 2'b01 || HMASTER !== 1'b0 || HMASTER_D !== 1'b0) begin errors++; $display("FAIL mid_reset got %b/%b/%b want 01/0/0", HGRANT, HMASTER, HMASTER_D); end
    HRESET = 0; HREADY = 1;
  endtask

  task automatic test_random();
    logic [31:0] ea, ew;
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      HREADY = ($urandom_range(3) != 0);
      HRESET = ($urandom_range(60) == 0);
      #1;
      ea = mm ? M1_HADDR : M0_HADDR;
      ew = md ? M1_HWDATA : M0_HWDATA;
      vectors++;
      if (HGRANT !== (mg == 1 ? 2'b10 : 2'b01) || HMASTER !== 1'(mm) || HMASTER_D !== 1'(md) ||
          HADDR !== ea || HWDATA !== ew || HTRANS !== (mm ? M1_HTRANS : M0_HTRANS) ||
          HWRITE !== (mm ? M1_HWRITE : M0_HWRITE) || HSIZE !== (mm ? M1_HSIZE : M0_HSIZE)) begin
        errors++;
        $display("FAIL random%0d got g=%b m=%b md=%b a=%h w=%h want g=%0d m=%0d md=%0d a=%h w=%h",
                 i, HGRANT, HMASTER, HMASTER_D, HADDR, HWDATA, mg, mm, md, ea, ew);
      end
      tick();
    end
    HRESET = 0;
  endtask

  initial begin
    HCLK = 0; HRESET = 1; HREADY = 1;
    rand_inputs();
    test_reset();
    test_single();
    test_wait_states();
    test_burst_hold();
    test_tie();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
